// File: rtl/master_read.sv
// AXI read-channel initiator: turns one req/addr/len request into a single INCR burst and returns each beat.
// Optional stall watchdog in ADDR/DATA is compiled in with `define MASTER_READ_TIMEOUT_EN.
module master_read #(
   parameter logic [3:0] MASTER_ID      = 4'd0,
   parameter int         TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req,
   input  logic [31:0] req_addr,
   input  logic [3:0]  req_len,
   output logic [31:0] rdata_out,
   output logic        rdata_vld,
   output logic        done,
   output logic        err,
   output logic        busy,
   output logic [3:0]  ARID,
   output logic [31:0] ARADDR,
   output logic [3:0]  ARLEN,
   output logic [2:0]  ARSIZE,
   output logic [1:0]  ARBURST,
   output logic        ARVALID,
   input  logic        ARREADY,
   input  logic [7:0]  RID,
   input  logic [31:0] RDATA,
   input  logic [1:0]  RRESP,
   input  logic        RLAST,
   input  logic        RVALID,
   output logic        RREADY,
   output logic [1:0]  dbg_state_o
);

   // Valid/ready: a transfer happens on a rising clk edge where both valid and ready are high.
   // ARVALID is held with ARADDR/ARLEN stable until accepted; RREADY is high for the whole DATA phase.
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ADDR = 2'd1,
      S_DATA = 2'd2
   } state_e;

   state_e      state_q, state_d;
   logic [31:0] addr_q, addr_d;
   logic [3:0]  len_q, len_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        serr_q, serr_d;
   logic [31:0] rdata_q, rdata_d;
   logic        rvld_q, rvld_d;
   logic        done_q, done_d;
   logic        derr_q, derr_d;

   logic        ar_hs;
   logic        r_hs;
   logic        beat_err;
   logic        tmo_hit;
   logic        unused_rid_hi;

   assign ar_hs = (state_q == S_ADDR) && ARREADY;
   assign r_hs  = (state_q == S_DATA) && RVALID;

   // Beat index cnt_q is zero-based: the beat with index len must be the one carrying RLAST.
   assign beat_err = (RRESP != 2'b00)
                   || (RID[3:0] != MASTER_ID)
                   || (RLAST ? (cnt_q != len_q) : (cnt_q == len_q));

   assign unused_rid_hi = ^RID[7:4];

`ifdef MASTER_READ_TIMEOUT_EN
   localparam logic [7:0] TMO_LIMIT = 8'(TIMEOUT_CYCLES);

   logic [7:0] tmo_q, tmo_d;

   // Counts stalled cycles; any handshake or a return to IDLE restarts it.
   always_comb begin
      tmo_d = 8'd0;
      if ((state_q != S_IDLE) && !ar_hs && !r_hs) begin
         tmo_d = tmo_q + 8'd1;
      end
   end

   assign tmo_hit = (state_q != S_IDLE) && !ar_hs && !r_hs && (tmo_q == TMO_LIMIT);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tmo_q <= 8'd0;
      end else begin
         tmo_q <= tmo_d;
      end
   end
`else
   localparam int unused_timeout_cycles = TIMEOUT_CYCLES;

   assign tmo_hit = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      len_d   = len_q;
      cnt_d   = cnt_q;
      serr_d  = serr_q;
      rdata_d = rdata_q;
      rvld_d  = 1'b0;
      done_d  = 1'b0;
      derr_d  = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (req) begin
               addr_d  = req_addr;
               len_d   = req_len;
               cnt_d   = 4'd0;
               serr_d  = 1'b0;
               state_d = S_ADDR;
            end
         end
         S_ADDR: begin
            if (ar_hs) begin
               state_d = S_DATA;
            end
         end
         S_DATA: begin
            if (r_hs) begin
               rdata_d = RDATA;
               rvld_d  = 1'b1;
               cnt_d   = (cnt_q == 4'hF) ? cnt_q : cnt_q + 4'd1;
               serr_d  = serr_q | beat_err;
               if (RLAST) begin
                  state_d = S_IDLE;
                  done_d  = 1'b1;
                  derr_d  = serr_q | beat_err;
               end
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      if (tmo_hit) begin
         state_d = S_IDLE;
         serr_d  = 1'b1;
         done_d  = 1'b1;
         derr_d  = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         addr_q  <= 32'd0;
         len_q   <= 4'd0;
         cnt_q   <= 4'd0;
         serr_q  <= 1'b0;
         rdata_q <= 32'd0;
         rvld_q  <= 1'b0;
         done_q  <= 1'b0;
         derr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         len_q   <= len_d;
         cnt_q   <= cnt_d;
         serr_q  <= serr_d;
         rdata_q <= rdata_d;
         rvld_q  <= rvld_d;
         done_q  <= done_d;
         derr_q  <= derr_d;
      end
   end

   // Channel controls decode straight from the state register so a reset drops them at once.
   assign ARVALID     = (state_q == S_ADDR);
   assign RREADY      = (state_q == S_DATA);
   assign busy        = (state_q != S_IDLE);
   assign ARID        = MASTER_ID;
   assign ARADDR      = addr_q;
   assign ARLEN       = len_q;
   assign ARSIZE      = 3'b010;
   assign ARBURST     = 2'b01;
   assign rdata_out   = rdata_q;
   assign rdata_vld   = rvld_q;
   assign done        = done_q;
   assign err         = derr_q;
   assign dbg_state_o = state_q;

endmodule
